// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces pushbutton pins against a ms timebase,
// producing held levels, press/release pulses and a single-key code.
module button_conditioner #(
    parameter int N_BTN       = 4,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ticks_per_milli,
    input  logic             invert,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             key_valid,
    output logic [2:0]       key_code,
    output logic             multi_press
);
    typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_t;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_MS - 1);

    logic [N_BTN-1:0] sync1_q, sync2_q, s;
    logic [15:0]      pre_q, pre_d, t_m1;
    logic             tick;
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [7:0]       cnt_q [N_BTN];
    logic [7:0]       cnt_d [N_BTN];
    logic [N_BTN-1:0] level_q, level_d, press_q, press_d, release_q, release_d;
    logic             key_valid_q, key_valid_d, multi_q, multi_d;
    logic [2:0]       key_code_q, key_code_d, idx;
    logic [3:0]       n_press;
    logic             others_held;

    assign s     = sync2_q ^ {N_BTN{invert}};
    // A zero period behaves as one, giving a tick every cycle.
    assign t_m1  = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    assign tick  = pre_q == t_m1;
    assign pre_d = tick ? 16'd0 : pre_q + 16'd1;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            level_d[i]   = level_q[i];
            press_d[i]   = 1'b0;
            release_d[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (s[i]) begin
                        state_d[i] = PRESS_PEND;
                        cnt_d[i]   = 8'd0;
                    end
                end
                PRESS_PEND: begin
                    if (!s[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = 8'd0;
                    end else if (tick) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = HELD;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
                HELD: begin
                    if (!s[i]) begin
                        state_d[i] = REL_PEND;
                        cnt_d[i]   = 8'd0;
                    end
                end
                REL_PEND: begin
                    if (s[i]) begin
                        state_d[i] = HELD;
                    end else if (tick) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i]   = IDLE;
                            level_d[i]   = 1'b0;
                            release_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // A button released in the same cycle already has level 0, so it never blocks a key.
    always_comb begin
        n_press = 4'd0;
        idx     = 3'd0;
        for (int i = 0; i < N_BTN; i++) begin
            if (press_q[i]) begin
                n_press = n_press + 4'd1;
                idx     = 3'(i);
            end
        end
        others_held = |(level_q & ~press_q);
        key_valid_d = (n_press == 4'd1) && !others_held;
        multi_d     = (n_press >= 4'd2) || ((n_press != 4'd0) && others_held);
        key_code_d  = key_valid_d ? idx : key_code_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pre_q       <= '0;
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 3'd0;
            multi_q     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= 8'd0;
            end
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            pre_q       <= pre_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            multi_q     <= multi_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign multi_press = multi_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table-driven and scoreboarded bench for button_conditioner.
module tb_button_conditioner;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          invert = 1'b0;
    logic [15:0]   tpm = 16'd2;
    logic [NB-1:0] raw = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release;
    logic          key_valid, multi_press;
    logic [2:0]    key_code;

    button_conditioner #(.N_BTN(NB), .DEBOUNCE_MS(3)) dut (
        .clk(clk), .rst(rst), .ticks_per_milli(tpm), .invert(invert), .btn_raw(raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .key_valid(key_valid), .key_code(key_code), .multi_press(multi_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       multi;
        logic [2:0] code;
    } ev_t;

    typedef struct {
        logic [NB-1:0] raw;
        int            cycles;
        logic [NB-1:0] level;
        int            ev;
        logic [2:0]    code;
    } vec_t;

    int      checks = 0;
    int      failures = 0;
    int      press_cnt[NB];
    int      rel_cnt[NB];
    int      p0[NB];
    int      r0[NB];
    ev_t     exp_q[$];
    ev_t     e;
    logic [NB-1:0] prev_press = '0;
    logic [2:0]    last_code = 3'd0;
    vec_t    tbl[12];

    task automatic check(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < NB; i++) begin
            p0[i] = press_cnt[i];
            r0[i] = rel_cnt[i];
        end
    endtask

    task automatic check_deltas(input string name, input logic [NB-1:0] pm, input logic [NB-1:0] rm);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s_press%0d", name, i), press_cnt[i] - p0[i], int'(pm[i]), int'(pm[i]));
            check($sformatf("%s_release%0d", name, i), rel_cnt[i] - r0[i], int'(rm[i]), int'(rm[i]));
        end
    endtask

    task automatic wait_level(input int b, input logic v, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (btn_level[b] !== v && n < 20);
    endtask

    // Counts pulses and matches key events against the expected-event queue.
    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            press_cnt[i] += int'(btn_press[i]);
            rel_cnt[i]   += int'(btn_release[i]);
        end
        if (key_valid || multi_press) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key_event", int'({key_valid, multi_press}), 0, 0);
            end else begin
                e = exp_q.pop_front();
                check("key_multi", int'(multi_press), int'(e.multi), int'(e.multi));
                check("key_valid", int'(key_valid), int'(!e.multi), int'(!e.multi));
                if (e.multi) begin
                    check("key_code_hold", int'(key_code), int'(last_code), int'(last_code));
                end else begin
                    check("key_code", int'(key_code), int'(e.code), int'(e.code));
                    check("key_after_single_press", $countones(prev_press), 1, 1);
                    last_code = e.code;
                end
            end
        end
        prev_press = btn_press;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [NB-1:0] prev;
        tbl[0]  = '{4'b0000, 20, 4'b0000, 0, 3'd0};
        tbl[1]  = '{4'b0001, 20, 4'b0001, 1, 3'd0};
        tbl[2]  = '{4'b1001, 20, 4'b1001, 2, 3'd0};
        tbl[3]  = '{4'b0000, 20, 4'b0000, 0, 3'd0};
        tbl[4]  = '{4'b0011, 20, 4'b0011, 2, 3'd0};
        tbl[5]  = '{4'b0001, 20, 4'b0001, 0, 3'd0};
        tbl[6]  = '{4'b1000, 20, 4'b1000, 1, 3'd3};
        tbl[7]  = '{4'b0000, 20, 4'b0000, 0, 3'd0};
        tbl[8]  = '{4'b0010, 20, 4'b0010, 1, 3'd1};
        tbl[9]  = '{4'b0110, 20, 4'b0110, 2, 3'd0};
        tbl[10] = '{4'b0100, 20, 4'b0100, 0, 3'd0};
        tbl[11] = '{4'b0000, 20, 4'b0000, 0, 3'd0};

        cyc(3);
        check("reset_outputs", int'({btn_level, btn_press, btn_release, key_valid, multi_press, key_code}), 0, 0);
        rst = 1'b0;

        // Clean press of button 2 with latency window
        snap();
        exp_q.push_back('{1'b0, 3'd2});
        raw = 4'b0100;
        wait_level(2, 1'b1, n);
        check("clean_press_latency", n, 7, 9);
        cyc(10);
        check_deltas("clean", 4'b0100, 4'b0000);
        check("clean_pending", exp_q.size(), 0, 0);

        prev = 4'b0100;
        for (int k = 0; k < 12; k++) begin
            snap();
            if (tbl[k].ev == 1) exp_q.push_back('{1'b0, tbl[k].code});
            if (tbl[k].ev == 2) exp_q.push_back('{1'b1, 3'd0});
            raw = tbl[k].raw;
            cyc(tbl[k].cycles);
            check($sformatf("vec%0d_level", k), int'(btn_level), int'(tbl[k].level), int'(tbl[k].level));
            check_deltas($sformatf("vec%0d", k), tbl[k].level & ~prev, prev & ~tbl[k].level);
            check($sformatf("vec%0d_pending", k), exp_q.size(), 0, 0);
            prev = tbl[k].level;
        end

        // Bounce on button 0, then steady press
        snap();
        raw = 4'b0001; cyc(2);
        raw = 4'b0000; cyc(2);
        raw = 4'b0001; cyc(2);
        raw = 4'b0000; cyc(2);
        check("bounce_no_press", press_cnt[0] - p0[0], 0, 0);
        exp_q.push_back('{1'b0, 3'd0});
        raw = 4'b0001;
        wait_level(0, 1'b1, n);
        check("bounce_latency", n, 7, 9);
        cyc(10);
        check_deltas("bounce", 4'b0001, 4'b0000);
        check("bounce_pending", exp_q.size(), 0, 0);
        raw = 4'b0000; cyc(20);
        check("bounce_released", int'(btn_level), 0, 0);

        // Release of button 1 with a one-cycle glitch during release debounce
        exp_q.push_back('{1'b0, 3'd1});
        raw = 4'b0010; cyc(20);
        check("glitch_held_level", int'(btn_level), 2, 2);
        snap();
        raw = 4'b0000; cyc(4);
        raw = 4'b0010; cyc(1);
        raw = 4'b0000;
        wait_level(1, 1'b0, n);
        check("glitch_release_latency", n, 7, 9);
        cyc(5);
        check_deltas("glitch", 4'b0000, 4'b0010);
        check("glitch_pending", exp_q.size(), 0, 0);

        // Reset in the middle of a press debounce
        snap();
        raw = 4'b0100; cyc(6);
        check("pend_no_press", press_cnt[2] - p0[2], 0, 0);
        rst = 1'b1; cyc(1);
        check("midreset_outputs", int'({btn_level, btn_press, btn_release, key_valid, multi_press, key_code}), 0, 0);
        exp_q.push_back('{1'b0, 3'd2});
        rst = 1'b0;
        wait_level(2, 1'b1, n);
        check("post_reset_latency", n, 7, 9);
        cyc(3);
        check_deltas("post_reset", 4'b0100, 4'b0000);
        raw = 4'b0000; cyc(20);

        // ticks_per_milli=0 acts as a one-cycle millisecond
        rst = 1'b1; tpm = 16'd0; cyc(2);
        exp_q.push_back('{1'b0, 3'd2});
        rst = 1'b0; raw = 4'b0100;
        wait_level(2, 1'b1, n);
        check("tpm0_latency", n, 6, 6);
        raw = 4'b0000; cyc(20);
        check("tpm0_released", int'(btn_level), 0, 0);

        // Active-low pins
        rst = 1'b1; tpm = 16'd2; invert = 1'b1; raw = 4'b1111; cyc(2);
        rst = 1'b0;
        snap();
        cyc(30);
        check("inv_idle_level", int'(btn_level), 0, 0);
        check_deltas("inv_idle", 4'b0000, 4'b0000);
        exp_q.push_back('{1'b0, 3'd1});
        raw = 4'b1101; cyc(20);
        check("inv_press_level", int'(btn_level), 2, 2);
        raw = 4'b1111; cyc(20);
        check("inv_release_level", int'(btn_level), 0, 0);
        check_deltas("inv", 4'b0010, 4'b0010);
        check("final_pending", exp_q.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
